// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: one bus cycle per load/store, pipeline
// stall until ack, load alignment, misalignment and timeout guarding.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       addr_lo;
  logic             byte_mode;
  logic             req_one;
  logic             req_bad;
  logic [7:0]       rd_byte;

  assign req_one = mem_read ^ mem_write;
  assign req_bad = (mem_read & mem_write) |
                   (req_one & ~byte_en & (addr[1:0] != 2'b00));

  // Freeze the pipeline from the request cycle until the retire cycle.
  assign stall = (state == BUSY) |
                 ((state == IDLE) & (mem_read | mem_write));

  // Pick the addressed byte lane out of the returned word.
  always_comb begin
    rd_byte = bus_rdata[7:0];
    case (addr_lo)
      2'd0: rd_byte = bus_rdata[7:0];
      2'd1: rd_byte = bus_rdata[15:8];
      2'd2: rd_byte = bus_rdata[23:16];
      2'd3: rd_byte = bus_rdata[31:24];
      default: rd_byte = bus_rdata[7:0];
    endcase
  end

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_lo    <= 2'b00;
      byte_mode  <= 1'b0;
      bus_rd     <= 1'b0;
      bus_wr     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_sel    <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      access_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_valid <= 1'b0;
          access_err <= 1'b0;
          if (req_bad) begin
            state      <= DONE;
            access_err <= 1'b1;
            load_data  <= '0;
          end else if (req_one) begin
            state     <= BUSY;
            cnt       <= '0;
            bus_rd    <= mem_read;
            bus_wr    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            addr_lo   <= addr[1:0];
            byte_mode <= byte_en;
            if (byte_en) begin
              bus_sel   <= 4'b0001 << addr[1:0];
              bus_wdata <= {4{store_data[7:0]}};
            end else begin
              bus_sel   <= 4'b1111;
              bus_wdata <= store_data;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus_ack) begin
            state  <= DONE;
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
            if (bus_rd) begin
              load_valid <= 1'b1;
              load_data  <= byte_mode ? {24'b0, rd_byte} : bus_rdata;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state      <= DONE;
            bus_rd     <= 1'b0;
            bus_wr     <= 1'b0;
            access_err <= 1'b1;
            load_data  <= '0;
          end
        end
        DONE: begin
          state      <= IDLE;
          cnt        <= '0;
          load_valid <= 1'b0;
          access_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        byte_en;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ld = '0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .addr(addr), .store_data(store_data),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .access_err(access_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One instruction through the controller. Starts just after a rising
  // edge with the DUT in IDLE and ends just after the edge back to IDLE.
  // delay = BUSY cycle index on which ack arrives; >= TIMEOUT means never.
  task automatic run_txn(input logic rd, input logic wr, input logic be,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int delay, input logic [31:0] rdata,
                         input string tag);
    logic        none, bad, timed;
    int          ncyc;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    none   = !rd && !wr;
    bad    = (rd && wr) || ((rd ^ wr) && !be && a[1:0] != 2'b00);
    timed  = delay >= TIMEOUT;
    ncyc   = timed ? TIMEOUT : delay + 1;
    e_addr = {a[31:2], 2'b00};
    e_sel  = be ? (4'b0001 << a[1:0]) : 4'b1111;
    e_wdata = be ? {4{sd[7:0]}} : sd;

    mem_read = rd; mem_write = wr; byte_en = be;
    addr = a; store_data = sd;
    @(negedge clk);
    checks++;
    if (stall !== !none) begin
      errors++;
      $display("FAIL %s req_stall: got %b want %b", tag, stall, !none);
    end
    checks++;
    if (bus_rd !== 1'b0 || bus_wr !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_bus: got rd=%b wr=%b want 0", tag, bus_rd, bus_wr);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; store_data = $urandom; byte_en = $urandom_range(0, 1);
    if (none) return;

    if (!bad) begin
      for (int c = 0; c < ncyc; c++) begin
        bus_ack   = (c == delay);
        bus_rdata = (c == delay) ? rdata : $urandom;
        @(negedge clk);
        checks++;
        if (bus_rd !== rd || bus_wr !== wr || stall !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_ctl c=%0d: got rd=%b wr=%b stall=%b want rd=%b wr=%b stall=1",
                   tag, c, bus_rd, bus_wr, stall, rd, wr);
        end
        checks++;
        if (bus_addr !== e_addr || bus_sel !== e_sel) begin
          errors++;
          $display("FAIL %s busy_addr c=%0d: got %h/%b want %h/%b",
                   tag, c, bus_addr, bus_sel, e_addr, e_sel);
        end
        if (wr) begin
          checks++;
          if (bus_wdata !== e_wdata) begin
            errors++;
            $display("FAIL %s busy_wdata: got %h want %h", tag, bus_wdata, e_wdata);
          end
        end
        @(posedge clk); #1;
      end
      if (timed) exp_ld = '0;
      else if (rd) exp_ld = be ? ((rdata >> (8 * a[1:0])) & 32'hFF) : rdata;
    end else begin
      exp_ld = '0;
    end

    // Stray ack in the retire cycle must be ignored.
    bus_ack = $urandom_range(0, 1);
    bus_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bus_rd !== 1'b0 || bus_wr !== 1'b0) begin
      errors++;
      $display("FAIL %s done_ctl: got stall=%b rd=%b wr=%b want 0", tag, stall, bus_rd, bus_wr);
    end
    checks++;
    if (load_valid !== (rd && !bad && !timed) || access_err !== (bad || timed)) begin
      errors++;
      $display("FAIL %s done_flags: got lv=%b err=%b want lv=%b err=%b", tag,
               load_valid, access_err, rd && !bad && !timed, bad || timed);
    end
    checks++;
    if (load_data !== exp_ld) begin
      errors++;
      $display("FAIL %s load_data: got %h want %h", tag, load_data, exp_ld);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 0; mem_write = 0; byte_en = 0;
    addr = '0; store_data = '0; bus_rdata = '0; bus_ack = 0;
    #1;
    checks++;
    if ({bus_rd, bus_wr, stall, load_valid, access_err} !== 5'b0 ||
        bus_addr !== '0 || bus_wdata !== '0 || bus_sel !== '0 || load_data !== '0) begin
      errors++;
      $display("FAIL reset: got rd=%b wr=%b st=%b lv=%b err=%b a=%h wd=%h sel=%b ld=%h want all 0",
               bus_rd, bus_wr, stall, load_valid, access_err, bus_addr, bus_wdata, bus_sel, load_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_ld = '0;
  endtask

  task automatic test_word_load();
    run_txn(1, 0, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, "word_load");
  endtask

  task automatic test_byte_load();
    run_txn(1, 0, 1, 32'h203, 32'h0, 0, 32'hAABBCCDD, "byte_load3");
    run_txn(1, 0, 1, 32'h201, 32'h0, 2, 32'hAABBCCDD, "byte_load1");
  endtask

  task automatic test_byte_store();
    run_txn(0, 1, 1, 32'h302, 32'h12345678, 0, 32'h0, "byte_store");
    run_txn(0, 1, 0, 32'h304, 32'hCAFEF00D, 3, 32'h0, "word_store");
  endtask

  task automatic test_misaligned();
    run_txn(1, 0, 1, 32'h101, 32'h0, 0, 32'h11223344, "prime_ld");
    run_txn(1, 0, 0, 32'h102, 32'h0, 0, 32'h0, "misaligned");
    run_txn(1, 1, 0, 32'h100, 32'h55, 0, 32'h0, "rd_wr_conflict");
  endtask

  task automatic test_timeout();
    run_txn(1, 0, 0, 32'h400, 32'h0, TIMEOUT + 5, 32'h0, "timeout");
    run_txn(1, 0, 0, 32'h404, 32'h0, TIMEOUT - 1, 32'h0BADF00D, "ack_last");
  endtask

  task automatic test_reset_mid_busy();
    mem_read = 1; byte_en = 0; addr = 32'h500;
    @(posedge clk); #1;
    mem_read = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_rd !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: got rd=%b stall=%b want 0", bus_rd, stall);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_ld = '0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (load_valid !== 1'b0 || bus_rd !== 1'b0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL late_ack: got lv=%b rd=%b ld=%h want 0", load_valid, bus_rd, load_data);
    end
    @(posedge clk); #1 bus_ack = 1'b0;
    run_txn(1, 0, 0, 32'h508, 32'h0, 0, 32'h13579BDF, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int k, d;
      logic rd, wr, be;
      logic [31:0] a;
      k  = $urandom_range(0, 9);
      rd = (k == 1) || (k >= 2 && k <= 5);
      wr = (k == 1) || (k >= 6);
      be = $urandom_range(0, 1);
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      d  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TIMEOUT + 2)
                                       : $urandom_range(0, 3);
      run_txn(rd, wr, be, a, $urandom, d, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
